// File: rtl/stream_pkg.sv
// Shared encodings for the stream multiplexer: arbiter states and mode values.
package stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: first requesting channel after 'last', with wrap-around.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = SEL_W'((32'(last) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 packet-aware stream multiplexer with fixed or round-robin selection
// and a registered one-beat output stage.
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     grant,
  output logic                 busy
);

  arb_state_e       state, state_nx;
  logic             can_accept;
  logic             sel_ok;
  logic [SEL_W-1:0] sel_idx;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic             xfer;
  logic             beat_last;

  assign can_accept = !out_valid || out_ready;
  assign xfer       = |(in_ready & in_valid);
  assign beat_last  = in_last[sel_idx];
  assign busy       = (state == LOCKED);

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (in_valid),
    .last  (grant),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer && !beat_last) state_nx = LOCKED;
      LOCKED:  if (xfer && beat_last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // While locked, grant doubles as the lock channel: it was loaded by the
  // IDLE transfer that opened the packet and holds until the packet ends.
  always_comb begin
    sel_ok   = 1'b0;
    sel_idx  = '0;
    in_ready = '0;
    if (state == LOCKED) begin
      sel_ok  = 1'b1;
      sel_idx = grant;
    end else if (mode == MODE_FIXED) begin
      if (int'(sel) < N) begin
        sel_ok  = 1'b1;
        sel_idx = sel;
      end
    end else begin
      sel_ok  = rr_found;
      sel_idx = rr_idx;
    end
    if (rst_n && sel_ok && can_accept) in_ready[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      grant     <= SEL_W'(N - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(sel_idx)*WIDTH +: WIDTH];
        out_last  <= beat_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && state == IDLE) grant <= sel_idx;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: per-cycle comparison against a transaction-level
// model plus directed scenarios with hand-computed expectations.
module tb_stream_mux_rr;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH*W-1:0] in_data = '0;
  logic [NCH-1:0]   in_valid = '0;
  logic [NCH-1:0]   in_last = '0;
  logic [NCH-1:0]   in_ready;
  logic             mode = 1'b0;
  logic [1:0]       sel = '0;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready = 1'b1;
  logic [1:0]       grant;
  logic             busy;

  logic [5*W-1:0]   d5_in_data = '0;
  logic [4:0]       d5_in_valid = '0;
  logic [4:0]       d5_in_last = '1;
  logic [4:0]       d5_in_ready;
  logic             d5_mode = 1'b0;
  logic [2:0]       d5_sel = '0;
  logic [W-1:0]     d5_out_data;
  logic             d5_out_valid;
  logic             d5_out_last;
  logic             d5_out_ready = 1'b1;
  logic [2:0]       d5_grant;
  logic             d5_busy;

  stream_mux_rr #(.WIDTH(W), .N(NCH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .grant(grant), .busy(busy)
  );

  stream_mux_rr #(.WIDTH(W), .N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5_in_data), .in_valid(d5_in_valid),
    .in_last(d5_in_last), .in_ready(d5_in_ready), .mode(d5_mode), .sel(d5_sel),
    .out_data(d5_out_data), .out_valid(d5_out_valid), .out_last(d5_out_last),
    .out_ready(d5_out_ready), .grant(d5_grant), .busy(d5_busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state describes what the outputs must show after the coming edge.
  bit       m_valid = 1'b0;
  bit       m_last  = 1'b0;
  int       m_data  = 0;
  int       m_grant = NCH - 1;
  bit       m_lock  = 1'b0;
  int       m_lock_ch = 0;

  always @(negedge clk) begin
    bit ok, can, xf, lst;
    int ch, c;
    int exp_rdy;
    if (chk_en) begin
      check("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        check("out_data", int'(out_data), m_data);
        check("out_last", int'(out_last), int'(m_last));
      end
      check("grant", int'(grant), m_grant);
      check("busy", int'(busy), int'(m_lock));
    end
    ok = 1'b0;
    ch = 0;
    if (m_lock) begin
      ok = 1'b1;
      ch = m_lock_ch;
    end else if (mode == 1'b0) begin
      if (int'(sel) < NCH) begin
        ok = 1'b1;
        ch = int'(sel);
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        c = (m_grant + k) % NCH;
        if (!ok && in_valid[c]) begin
          ok = 1'b1;
          ch = c;
        end
      end
    end
    can = !m_valid || out_ready;
    exp_rdy = (rst_n && ok && can) ? (1 << ch) : 0;
    if (chk_en) check("in_ready", int'(in_ready), exp_rdy);
    if (!rst_n) begin
      m_valid = 1'b0; m_last = 1'b0; m_data = 0;
      m_grant = NCH - 1; m_lock = 1'b0; m_lock_ch = 0;
    end else begin
      xf  = (exp_rdy != 0) && in_valid[ch];
      lst = in_last[ch];
      if (xf) begin
        m_valid = 1'b1;
        m_data  = int'(in_data[ch*W +: W]);
        m_last  = lst;
        if (!m_lock) begin
          m_grant = ch;
          if (!lst) begin
            m_lock    = 1'b1;
            m_lock_ch = ch;
          end
        end else if (lst) begin
          m_lock = 1'b0;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total %0d passed %0d", total, passed);
    $fatal(1);
  end

  initial begin
    // Reset state
    step();
    step();
    chk_en = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_grant", int'(grant), 3);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;

    // Fixed select on channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_last = 4'b1111;
    set_ch(2, 8'hA5); out_ready = 1'b1;
    #1 check("fix_in_ready", int'(in_ready), 4'b0100);
    step();
    check("fix_data", int'(out_data), 8'hA5);
    check("fix_last", int'(out_last), 1);
    check("fix_grant", int'(grant), 2);
    in_valid = '0;
    step();

    // Round-robin over all channels, single-beat packets
    pulse_reset();
    mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    for (int i = 0; i < NCH; i++) set_ch(i, W'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_grant", int'(grant), k % 4);
      check("rr_data", int'(out_data), 8'h10 + (k % 4));
    end
    in_valid = '0;
    step();

    // Packet lock: channel 1 sends 3 beats while channel 0 stays valid
    pulse_reset();
    mode = 1'b1; in_valid = 4'b0011; in_last = 4'b0001;
    set_ch(0, 8'hC0); set_ch(1, 8'hB1);
    step();
    check("lk_pre_grant", int'(grant), 0);
    check("lk_pre_data", int'(out_data), 8'hC0);
    check("lk_b1_ready", int'(in_ready), 4'b0010);
    step();
    check("lk_b1_data", int'(out_data), 8'hB1);
    check("lk_b1_busy", int'(busy), 1);
    set_ch(1, 8'hB2);
    #1 check("lk_b2_ready", int'(in_ready), 4'b0010);
    step();
    check("lk_b2_data", int'(out_data), 8'hB2);
    check("lk_b2_busy", int'(busy), 1);
    set_ch(1, 8'hB3); in_last = 4'b0011;
    step();
    check("lk_b3_data", int'(out_data), 8'hB3);
    check("lk_b3_last", int'(out_last), 1);
    check("lk_b3_busy", int'(busy), 0);
    step();
    check("lk_ch0_data", int'(out_data), 8'hC0);
    check("lk_ch0_grant", int'(grant), 0);
    in_valid = '0;
    step();

    // Backpressure holds the output beat
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_last = 4'b1111;
    set_ch(1, 8'h55); out_ready = 1'b1;
    step();
    check("bp_first", int'(out_data), 8'h55);
    out_ready = 1'b0; set_ch(1, 8'h66);
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_ready", int'(in_ready), 0);
      step();
      check("bp_hold", int'(out_data), 8'h55);
      check("bp_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", int'(in_ready), 4'b0010);
    step();
    check("bp_next", int'(out_data), 8'h66);
    in_valid = '0;
    step();
    check("bp_no_dup", int'(out_valid), 0);

    // Out-of-range fixed select on a five-channel instance
    d5_mode = 1'b0; d5_sel = 3'd5; d5_in_valid = 5'b11111; d5_in_last = '1;
    d5_in_data[4*W +: W] = 8'h4E;
    for (int k = 0; k < 3; k++) begin
      #1 check("inv_ready", int'(d5_in_ready), 0);
      step();
      check("inv_valid", int'(d5_out_valid), 0);
    end
    d5_sel = 3'd4;
    #1 check("d5_ready", int'(d5_in_ready), 5'b10000);
    step();
    check("d5_valid", int'(d5_out_valid), 1);
    check("d5_data", int'(d5_out_data), 8'h4E);
    check("d5_grant", int'(d5_grant), 4);
    d5_in_valid = '0;

    // Reset in the middle of a packet
    mode = 1'b1; in_valid = 4'b0100; in_last = 4'b0000; set_ch(2, 8'h77);
    step();
    check("mr_busy", int'(busy), 1);
    check("mr_grant", int'(grant), 2);
    rst_n = 1'b0;
    #1 check("mr_rst_ready", int'(in_ready), 0);
    step();
    check("mr_out_valid", int'(out_valid), 0);
    check("mr_busy_clr", int'(busy), 0);
    check("mr_grant_rst", int'(grant), 3);
    rst_n = 1'b1; in_valid = '0;
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
